bus_arbiter: RTL and testbench

- Round-robin arbiter for the shared system bus.
- Serves up to eight bus masters (camera grabber, CPU data port, DMA and similar) that use the requestBus/busGrant handshake.
- Issues a one-cycle grant to one requester, then tracks the winner's transaction by watching the shared beginTransaction/endTransaction lines. It re-arbitrates only after the transaction closes.
- A begin-timeout and a transaction watchdog prevent a dead master from locking the bus.

---
 rtl/bus_arbiter.sv | 139 +++++++++++++
 tb/tb_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for the shared system bus.
// Tracks the owner's transaction and recovers from dead masters with two timeouts.
module bus_arbiter #(
    parameter int NUM_MASTERS         = 4,
    parameter int BEGIN_TIMEOUT       = 16,
    parameter int TRANSACTION_TIMEOUT = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] requests,
    output logic [NUM_MASTERS-1:0] grants,
    input  logic                   beginTransactionIn,
    input  logic                   endTransactionIn,
    input  logic                   busErrorIn,
    output logic                   busErrorOut,
    output logic [2:0]             activeMaster,
    output logic                   arbiterBusy
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int BW = $clog2(BEGIN_TIMEOUT);
    localparam int TW = $clog2(TRANSACTION_TIMEOUT);
    localparam logic [BW-1:0] BEGIN_LAST = BW'(BEGIN_TIMEOUT - 1);
    localparam logic [TW-1:0] TX_LAST    = TW'(TRANSACTION_TIMEOUT - 1);
    localparam logic [2:0]    LAST_INIT  = 3'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        BUSY
    } state_t;

    state_t                 state, state_n;
    logic [NUM_MASTERS-1:0] grants_n;
    logic [2:0]             active_n;
    logic                   busy_n;
    logic                   err_n;
    logic [2:0]             last_winner, last_n;
    logic [BW-1:0]          bcnt, bcnt_n;
    logic [TW-1:0]          tcnt, tcnt_n;

    logic [IW-1:0]          idx;
    logic [IW-1:0]          win;
    logic                   found;

    // Bus errors are left to the owner; it still closes with endTransaction.
    logic unused_bus_error;
    assign unused_bus_error = busErrorIn;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = IW'((int'(last_winner) + k) % NUM_MASTERS);
            if (!found && requests[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_n  = state;
        grants_n = '0;
        active_n = activeMaster;
        busy_n   = arbiterBusy;
        err_n    = 1'b0;
        last_n   = last_winner;
        bcnt_n   = bcnt;
        tcnt_n   = tcnt;
        unique case (state)
            IDLE: begin
                bcnt_n = '0;
                tcnt_n = '0;
                if (found) begin
                    state_n  = GRANTED;
                    grants_n = NUM_MASTERS'(1) << win;
                    active_n = 3'(win);
                    last_n   = 3'(win);
                    busy_n   = 1'b1;
                end
            end
            GRANTED: begin
                // Begin outranks a same-cycle end or an expiring timeout.
                if (beginTransactionIn) begin
                    state_n = BUSY;
                    bcnt_n  = '0;
                    tcnt_n  = TW'(1);
                end else if (bcnt == BEGIN_LAST) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    bcnt_n  = '0;
                end else begin
                    bcnt_n = bcnt + BW'(1);
                end
            end
            BUSY: begin
                if (endTransactionIn) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    tcnt_n  = '0;
                end else if (tcnt == TX_LAST) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    err_n   = 1'b1;
                    tcnt_n  = '0;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            grants       <= '0;
            activeMaster <= '0;
            arbiterBusy  <= 1'b0;
            busErrorOut  <= 1'b0;
            last_winner  <= LAST_INIT;
            bcnt         <= '0;
            tcnt         <= '0;
        end else begin
            state        <= state_n;
            grants       <= grants_n;
            activeMaster <= active_n;
            arbiterBusy  <= busy_n;
            busErrorOut  <= err_n;
            last_winner  <= last_n;
            bcnt         <= bcnt_n;
            tcnt         <= tcnt_n;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table, directed corner sequences and a randomized
// run against a timestamp-based reference model of the arbiter.
`timescale 1ns/1ps
module tb_bus_arbiter;
    localparam int N  = 4;
    localparam int BT = 16;
    localparam int TT = 1024;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] requests;
    logic [N-1:0] grants;
    logic         beginTransactionIn;
    logic         endTransactionIn;
    logic         busErrorIn;
    logic         busErrorOut;
    logic [2:0]   activeMaster;
    logic         arbiterBusy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bus_arbiter #(
        .NUM_MASTERS(N),
        .BEGIN_TIMEOUT(BT),
        .TRANSACTION_TIMEOUT(TT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .requests(requests),
        .grants(grants),
        .beginTransactionIn(beginTransactionIn),
        .endTransactionIn(endTransactionIn),
        .busErrorIn(busErrorIn),
        .busErrorOut(busErrorOut),
        .activeMaster(activeMaster),
        .arbiterBusy(arbiterBusy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         b;
        logic         e;
        logic         be;
        logic [N-1:0] g;
        logic         busy;
        logic [2:0]   act;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int r, input int b, input int e, input int be,
                       input int g, input int busy, input int act);
        vec_t v;
        v.req  = N'(r);
        v.b    = 1'(b);
        v.e    = 1'(e);
        v.be   = 1'(be);
        v.g    = N'(g);
        v.busy = 1'(busy);
        v.act  = 3'(act);
        vecs.push_back(v);
    endtask

    // Reference model: ownership tracked by grant/begin timestamps.
    int           m_owner;
    int           m_last;
    int           m_active;
    int           m_grant_cyc;
    int           m_begin_cyc;
    bit           m_open;
    logic [N-1:0] x_grants;
    logic         x_err;

    task automatic model_step(input logic [N-1:0] req, input logic b,
                              input logic e, input int c);
        int id;
        x_grants = '0;
        x_err    = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                id = (m_last + k) % N;
                if (m_owner < 0 && req[id]) begin
                    m_owner     = id;
                    m_last      = id;
                    m_active    = id;
                    m_grant_cyc = c + 1;
                    m_open      = 1'b0;
                    x_grants[id] = 1'b1;
                end
            end
        end else if (!m_open) begin
            if (b) begin
                m_open      = 1'b1;
                m_begin_cyc = c;
            end else if (c - m_grant_cyc == BT - 1) begin
                m_owner = -1;
            end
        end else begin
            if (e) begin
                m_owner = -1;
            end else if (c - m_begin_cyc == TT - 1) begin
                m_owner = -1;
                x_err   = 1'b1;
            end
        end
    endtask

    int end_cyc;
    int bcyc;
    int pulses;
    int err_at;
    int bad;
    bit got;
    logic err_busy;

    initial begin
        reset = 1'b0;
        requests = '0;
        beginTransactionIn = 1'b0;
        endTransactionIn = 1'b0;
        busErrorIn = 1'b0;
        #12;
        check("reset_grants", 32'(grants), 32'(0));
        check("reset_busy", 32'(arbiterBusy), 32'(0));
        check("reset_err", 32'(busErrorOut), 32'(0));
        check("reset_active", 32'(activeMaster), 32'(0));
        reset = 1'b1;

        add(4'b0100, 0, 0, 0, 4'b0100, 1, 2);
        add(4'b0000, 0, 0, 0, 4'b0000, 1, 2);
        add(4'b0000, 0, 0, 0, 4'b0000, 1, 2);
        add(4'b0000, 1, 0, 0, 4'b0000, 1, 2);
        add(4'b0000, 0, 0, 0, 4'b0000, 1, 2);
        add(4'b0000, 0, 0, 1, 4'b0000, 1, 2);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 1, 2);
        add(4'b0000, 0, 1, 0, 4'b0000, 0, 2);
        add(4'b0010, 0, 0, 0, 4'b0010, 1, 1);
        add(4'b0011, 1, 0, 0, 4'b0000, 1, 1);
        add(4'b0011, 0, 1, 0, 4'b0000, 0, 1);
        add(4'b0011, 0, 0, 0, 4'b0001, 1, 0);
        add(4'b0000, 1, 1, 0, 4'b0000, 1, 0);
        add(4'b0000, 0, 1, 0, 4'b0000, 0, 0);
        add(4'b0000, 1, 1, 0, 4'b0000, 0, 0);
        add(4'b1000, 0, 0, 0, 4'b1000, 1, 3);
        add(4'b0000, 1, 0, 0, 4'b0000, 1, 3);
        add(4'b0000, 0, 1, 0, 4'b0000, 0, 3);

        foreach (vecs[i]) begin
            requests = vecs[i].req;
            beginTransactionIn = vecs[i].b;
            endTransactionIn = vecs[i].e;
            busErrorIn = vecs[i].be;
            step();
            check($sformatf("vec%0d_grants", i), 32'(grants), 32'(vecs[i].g));
            check($sformatf("vec%0d_busy", i), 32'(arbiterBusy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_err", i), 32'(busErrorOut), 32'(0));
            if (vecs[i].busy)
                check($sformatf("vec%0d_active", i), 32'(activeMaster),
                      32'(vecs[i].act));
        end
        requests = '0;
        beginTransactionIn = 1'b0;
        endTransactionIn = 1'b0;
        busErrorIn = 1'b0;

        // all four requesting: strict rotation, two-cycle turnaround
        requests = 4'hF;
        end_cyc = 0;
        for (int n = 0; n < 5; n++) begin
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                step();
                if (grants != '0) got = 1'b1;
            end
            check($sformatf("rr%0d_seen", n), 32'(got), 32'(1));
            check($sformatf("rr%0d_order", n), 32'(grants), 32'(1 << (n % N)));
            if (n > 0) check($sformatf("rr%0d_turnaround", n),
                             32'(cyc - end_cyc), 32'(2));
            if (n == 4) requests = '0;
            beginTransactionIn = 1'b1;
            step();
            beginTransactionIn = 1'b0;
            step();
            step();
            endTransactionIn = 1'b1;
            end_cyc = cyc;
            step();
            endTransactionIn = 1'b0;
        end

        // master 3 never begins; master 0 waits behind it
        requests = 4'b1000;
        step();
        check("bto_grant", 32'(grants), 32'(4'b1000));
        requests = 4'b0001;
        bad = 0;
        pulses = 0;
        for (int k = 1; k < BT; k++) begin
            step();
            if (!arbiterBusy || grants != '0) bad++;
            if (busErrorOut) pulses++;
        end
        step();
        if (busErrorOut) pulses++;
        check("bto_held", 32'(bad), 32'(0));
        check("bto_release", 32'(arbiterBusy), 32'(0));
        check("bto_no_err", 32'(pulses), 32'(0));
        step();
        check("bto_next_grant", 32'(grants), 32'(4'b0001));

        // watchdog: begin with no end
        bcyc = cyc;
        beginTransactionIn = 1'b1;
        requests = '0;
        step();
        beginTransactionIn = 1'b0;
        pulses = 0;
        err_at = -1;
        err_busy = 1'b1;
        for (int k = 0; k < TT + 40; k++) begin
            step();
            if (busErrorOut) begin
                pulses++;
                err_at = cyc;
                err_busy = arbiterBusy;
            end
        end
        check("wd_pulses", 32'(pulses), 32'(1));
        check("wd_latency", 32'(err_at - bcyc), 32'(TT));
        check("wd_busy", 32'(err_busy), 32'(0));

        // end arrives in the expiry cycle
        requests = 4'b0010;
        step();
        check("wd2_grant", 32'(grants), 32'(4'b0010));
        bcyc = cyc;
        beginTransactionIn = 1'b1;
        requests = '0;
        step();
        beginTransactionIn = 1'b0;
        pulses = 0;
        while (cyc < bcyc + TT - 1) begin
            step();
            if (busErrorOut) pulses++;
        end
        endTransactionIn = 1'b1;
        step();
        endTransactionIn = 1'b0;
        check("wd2_busy", 32'(arbiterBusy), 32'(0));
        if (busErrorOut) pulses++;
        for (int k = 0; k < 3; k++) begin
            step();
            if (busErrorOut) pulses++;
        end
        check("wd2_no_err", 32'(pulses), 32'(0));

        // asynchronous reset in the middle of a transaction
        requests = 4'b0100;
        step();
        check("rst_grant", 32'(grants), 32'(4'b0100));
        beginTransactionIn = 1'b1;
        requests = '0;
        step();
        beginTransactionIn = 1'b0;
        step();
        step();
        check("rst_pre_busy", 32'(arbiterBusy), 32'(1));
        #2 reset = 1'b0;
        #1;
        check("rst_grants", 32'(grants), 32'(0));
        check("rst_busy", 32'(arbiterBusy), 32'(0));
        check("rst_err", 32'(busErrorOut), 32'(0));
        requests = 4'b0001;
        #2 reset = 1'b1;
        step();
        check("rst_after_grant", 32'(grants), 32'(4'b0001));
        check("rst_after_active", 32'(activeMaster), 32'(0));

        // randomized run against the model
        step();
        reset = 1'b0;
        requests = '0;
        #2 reset = 1'b1;
        m_owner = -1;
        m_last = N - 1;
        m_active = 0;
        m_open = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            requests = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) requests = '0;
            beginTransactionIn = ($urandom_range(0, 11) == 0);
            endTransactionIn = ($urandom_range(0, 5) == 0);
            busErrorIn = ($urandom_range(0, 7) == 0);
            model_step(requests, beginTransactionIn, endTransactionIn, cyc);
            step();
            check("rand_grants", 32'(grants), 32'(x_grants));
            check("rand_busy", 32'(arbiterBusy), 32'(m_owner >= 0));
            check("rand_err", 32'(busErrorOut), 32'(x_err));
            if (m_owner >= 0)
                check("rand_active", 32'(activeMaster), 32'(m_active));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got stuck at cycle %0d, want completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
